// File: rtl/sdram_arbiter_n.sv
// sdram_arbiter_n: N-client SDRAM arbiter with fixed-priority audio, round-robin fairness, burst guard and access timeout
module sdram_arbiter_n #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int PRIO_CLIENT = 1,
  parameter int MAX_BURST   = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 init_active,
  input  logic [NUM_CLIENTS-1:0]               cl_req,
  input  logic [NUM_CLIENTS-1:0]               cl_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]        cl_addr,
  input  logic [NUM_CLIENTS*(DATA_W/8)-1:0]    cl_be,
  input  logic [NUM_CLIENTS*DATA_W-1:0]        cl_wrdata,
  output logic [NUM_CLIENTS-1:0]               cl_ac,
  output logic [NUM_CLIENTS-1:0]               cl_grant,
  output logic [DATA_W-1:0]                    cl_rddata,
  output logic [ADDR_W-1:0]                    ar_addr,
  output logic [DATA_W/8-1:0]                  ar_be,
  output logic                                 ar_read,
  output logic                                 ar_write,
  output logic [DATA_W-1:0]                    ar_wrdata,
  input  logic                                 ar_ac,
  input  logic [DATA_W-1:0]                    ar_rddata,
  output logic                                 err_timeout
);
  localparam int BE_W = DATA_W / 8;
  localparam int IW   = NUM_CLIENTS > 2 ? $clog2(NUM_CLIENTS) : 1;
  localparam int BW   = $clog2(MAX_BURST + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
  state_t state, state_n;
  logic [NUM_CLIENTS-1:0] elig, prio_bit, rr_mask;
  logic [IW-1:0] rr_ptr, rr_g, g;
  logic [IW:0] j;
  logic [BW-1:0] burst;
  logic [TW-1:0] tmo_cnt;
  logic any, others, prio_win;
  assign cl_ac = cl_grant & {NUM_CLIENTS{ar_ac && state == ACCESS}};
  assign cl_rddata = ar_rddata;
  // winner selection: audio first unless its burst budget is spent, otherwise round-robin from rr_ptr
  always_comb begin
    elig = cl_req & (init_active ? NUM_CLIENTS'(1) : {NUM_CLIENTS{1'b1}});
    prio_bit = NUM_CLIENTS'(1) << PRIO_CLIENT;
    others = |(elig & ~prio_bit);
    any = |elig;
    prio_win = elig[PRIO_CLIENT] && !(burst == BW'(MAX_BURST) && others);
    rr_mask = elig & ~prio_bit;
    rr_g = '0;
    j = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      j = {1'b0, rr_ptr} + (IW+1)'(k);
      j = (j >= (IW+1)'(NUM_CLIENTS)) ? j - (IW+1)'(NUM_CLIENTS) : j;
      rr_g = rr_mask[j[IW-1:0]] ? j[IW-1:0] : rr_g;
    end
    g = prio_win ? IW'(PRIO_CLIENT) : rr_g;
  end
  // next-state: IDLE -> ACCESS on any eligible request, ACCESS -> RELEASE on ar_ac, one bubble back to IDLE
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && any) ? ACCESS :
              (state == ACCESS && ar_ac) ? RELEASE :
              (state == RELEASE) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // latch the winning request, track fairness state, and watch for a stuck controller
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_addr <= '0;
      ar_be <= '0;
      ar_wrdata <= '0;
      ar_read <= 1'b0;
      ar_write <= 1'b0;
      cl_grant <= '0;
      rr_ptr <= '0;
      burst <= '0;
      tmo_cnt <= '0;
      err_timeout <= 1'b0;
    end else if (state == IDLE && any) begin
      ar_addr <= cl_addr[g*ADDR_W +: ADDR_W];
      ar_be <= cl_be[g*BE_W +: BE_W];
      ar_wrdata <= cl_wrdata[g*DATA_W +: DATA_W];
      ar_read <= ~cl_we[g];
      ar_write <= cl_we[g];
      cl_grant <= NUM_CLIENTS'(1) << g;
      tmo_cnt <= '0;
      if (prio_win) burst <= !others ? '0 : (burst == BW'(MAX_BURST)) ? burst : burst + 1'b1;
      else begin
        burst <= '0;
        rr_ptr <= (g == IW'(NUM_CLIENTS - 1)) ? '0 : g + 1'b1;
      end
    end else if (state == ACCESS) begin
      if (ar_ac) begin
        ar_read <= 1'b0;
        ar_write <= 1'b0;
        cl_grant <= '0;
      end else if (tmo_cnt == TW'(TIMEOUT - 1)) err_timeout <= 1'b1;
      else tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
endmodule
